keypad_scan_debounce: RTL

//  Drives the 4x4 keypad rows, reads the synchronized columns, debounces presses and releases,
//  and emits one single-cycle newNum strobe plus a 4-bit key code per distinct press.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/tick_counter.sv | 26 ++
 rtl/keypad_scan_debounce.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: FSM states,
// the row/column-to-key-code map and the column priority encoder.
package keypad_pkg;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_t;

  // Indexed as KEYMAP[row][col]; element [0][0] sits in the MSBs.
  localparam logic [0:3][0:3][3:0] KEYMAP = {
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  function automatic logic [1:0] lowest_col(input logic [3:0] c);
    logic [1:0] idx;
    if (c[0])      idx = 2'd0;
    else if (c[1]) idx = 2'd1;
    else if (c[2]) idx = 2'd2;
    else           idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Clear/enable up-counter with a terminal-count flag at N-1.
// Clear has priority over enable; callers clear it before it passes N-1.
module tick_counter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == W'(N - 1));

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debounce; emits a one-cycle
// newNum strobe and a held key code for every accepted press.
module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int SCAN_TICKS     = 4,
  parameter int DEBOUNCE_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       newNum,
  output logic [3:0] num,
  output logic       scanning,
  output logic       waiting
);

  localparam int MAX_T = (SCAN_TICKS > DEBOUNCE_TICKS) ? SCAN_TICKS : DEBOUNCE_TICKS;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  kp_state_t  r_state;
  logic [1:0] r_row_idx;
  logic [1:0] r_col_idx;
  logic [3:0] r_rows;
  logic       r_new_num;
  logic [3:0] r_num;
  logic       r_scanning;
  logic       r_waiting;

  kp_state_t  w_state_next;
  logic [1:0] w_row_next;
  logic [1:0] w_col_next;
  logic       w_strobe;
  logic       w_scan_clr;
  logic       w_scan_en;
  logic       w_scan_tc;
  logic       w_deb_clr;
  logic       w_deb_en;
  logic       w_deb_tc;
  logic       w_key_bit;

  tick_counter #(.N(SCAN_TICKS), .W(CNT_W)) u_scan_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_scan_clr),
    .i_en  (w_scan_en),
    .o_tc  (w_scan_tc)
  );

  tick_counter #(.N(DEBOUNCE_TICKS), .W(CNT_W)) u_deb_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_deb_clr),
    .i_en  (w_deb_en),
    .o_tc  (w_deb_tc)
  );

  // Rows are frozen outside SCAN, so this bit always belongs to the latched key.
  assign w_key_bit = cols[r_col_idx];

  always_comb begin
    w_state_next = r_state;
    w_row_next   = r_row_idx;
    w_col_next   = r_col_idx;
    w_strobe     = 1'b0;
    w_scan_clr   = 1'b1;
    w_scan_en    = 1'b0;
    w_deb_clr    = 1'b1;
    w_deb_en     = 1'b0;
    case (r_state)
      SCAN: begin
        if (cols != 4'b0000) begin
          w_col_next   = lowest_col(cols);
          w_state_next = DEBOUNCE;
        end else if (w_scan_tc) begin
          w_row_next = r_row_idx + 2'd1;
        end else begin
          w_scan_clr = 1'b0;
          w_scan_en  = 1'b1;
        end
      end
      DEBOUNCE: begin
        if (!w_key_bit) begin
          w_state_next = SCAN;
        end else if (w_deb_tc) begin
          w_strobe     = 1'b1;
          w_state_next = HELD;
        end else begin
          w_deb_clr = 1'b0;
          w_deb_en  = 1'b1;
        end
      end
      HELD: begin
        if (!w_key_bit) begin
          w_state_next = RELEASE;
        end
      end
      RELEASE: begin
        if (w_key_bit) begin
          w_state_next = HELD;
        end else if (w_deb_tc) begin
          w_state_next = SCAN;
          w_row_next   = r_row_idx + 2'd1;
        end else begin
          w_deb_clr = 1'b0;
          w_deb_en  = 1'b1;
        end
      end
      default: begin
        w_state_next = SCAN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= SCAN;
      r_row_idx  <= 2'd0;
      r_col_idx  <= 2'd0;
      r_rows     <= 4'b0001;
      r_new_num  <= 1'b0;
      r_num      <= 4'h0;
      r_scanning <= 1'b1;
      r_waiting  <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_row_idx  <= w_row_next;
      r_col_idx  <= w_col_next;
      r_rows     <= 4'b0001 << w_row_next;
      r_new_num  <= w_strobe;
      if (w_strobe) begin
        r_num <= KEYMAP[r_row_idx][r_col_idx];
      end
      r_scanning <= (w_state_next == SCAN);
      r_waiting  <= (w_state_next == HELD) || (w_state_next == RELEASE);
    end
  end

  assign rows     = r_rows;
  assign newNum   = r_new_num;
  assign num      = r_num;
  assign scanning = r_scanning;
  assign waiting  = r_waiting;

endmodule
